bus_fabric: RTL and testbench

//  Parametrised address-decode fabric between the cpu (code + data ports) and NSLOT memory/peripheral slots.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_port_fsm.sv | 84 ++++++++
 rtl/bus_fabric.sv | 136 +++++++++++++
 tb/tb_bus_fabric.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and helpers for the cpu-to-slot bus fabric.
// Port FSM states, select-width function and error fill value.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } port_state_e;

  localparam logic ERR_FILL = 1'b0;

  function automatic int selw(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 5; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bus_port_fsm.sv
// One cpu-side port: decode, chip-select, wait/timeout, completion.
// Used for both the code and the data port of the fabric.
module bus_port_fsm
  import bus_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          NSLOT     = 16,
  parameter int          TIMEOUT   = 15,
  parameter logic [15:0] SLOT_EN   = 16'hffff,
  parameter bit          HAS_WRITE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [XLEN-1:0]  adrs,
  input  logic [XLEN-1:0]  din,
  input  logic [NSLOT-1:0] s_ready,
  output logic [NSLOT-1:0] cs,
  output logic [XLEN-1:0]  adrs_q,
  output logic [XLEN-1:0]  rdata,
  output logic             ready,
  output logic             err,
  output logic             busy
);

  localparam int SELW = selw(NSLOT);
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  port_state_e     state;
  logic [7:0]      timer;
  logic            absent;
  logic            we_q;
  logic [SELW-1:0] slot;
  logic            hit;

  assign slot = adrs[XLEN-1 -: SELW];
  assign busy = (state != IDLE);
  // only the selected slot can complete; cs is zero for absent slots
  assign hit  = |(s_ready & cs);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      timer  <= '0;
      absent <= 1'b0;
      we_q   <= 1'b0;
      cs     <= '0;
      adrs_q <= '0;
      rdata  <= '0;
      ready  <= 1'b0;
      err    <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            state  <= WAIT;
            adrs_q <= adrs;
            we_q   <= HAS_WRITE && we;
            timer  <= '0;
            absent <= !SLOT_EN[slot];
            cs     <= SLOT_EN[slot] ? (NSLOT'(1) << slot) : '0;
          end
        end
        WAIT: begin
          if (absent || hit || timer == TMO) begin
            state <= DONE;
            ready <= 1'b1;
            cs    <= '0;
            err   <= !hit;
            rdata <= (hit && !we_q) ? din : {XLEN{ERR_FILL}};
          end else begin
            timer <= timer + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Address-decode fabric between cpu code/data ports and NSLOT slots,
// with wait states, bus errors and latched maskable interrupts.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          NSLOT    = 16,
  parameter logic [15:0] SLOT_EN  = 16'hffff,
  parameter int          TIMEOUT  = 15,
  parameter logic [15:0] IRQ_EDGE = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req,
  input  logic [XLEN-1:0]       c_adrs,
  output logic [XLEN-1:0]       c_rdata,
  output logic                  c_ready,
  output logic                  c_err,
  output logic                  c_busy,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [XLEN/8-1:0]     d_wst,
  input  logic [XLEN-1:0]       d_adrs,
  input  logic [XLEN-1:0]       d_wdata,
  output logic [XLEN-1:0]       d_rdata,
  output logic                  d_ready,
  output logic                  d_err,
  output logic                  d_busy,
  output logic [NSLOT-1:0]      s_ccs,
  output logic [XLEN-1:0]       s_cadrs,
  output logic [NSLOT-1:0]      s_dcs,
  output logic                  s_dwe,
  output logic [XLEN/8-1:0]     s_dwst,
  output logic [XLEN-1:0]       s_dadrs,
  output logic [XLEN-1:0]       s_din,
  input  logic [NSLOT*XLEN-1:0] s_dout,
  input  logic [NSLOT-1:0]      s_cready,
  input  logic [NSLOT-1:0]      s_dready,
  input  logic [NSLOT-1:0]      s_irq,
  input  logic [NSLOT-1:0]      irq_en,
  input  logic [NSLOT-1:0]      irq_ack,
  output logic [NSLOT-1:0]      irq_pend,
  output logic                  irq
);

  localparam int SELW = selw(NSLOT);
  localparam logic [NSLOT-1:0] EDGE = IRQ_EDGE[NSLOT-1:0];

  logic [SELW-1:0]  c_sel;
  logic [SELW-1:0]  d_sel;
  logic [XLEN-1:0]  c_din;
  logic [XLEN-1:0]  d_din;
  logic [NSLOT-1:0] irq_hist;
  logic [NSLOT-1:0] rise;
  logic [NSLOT-1:0] pend_n;

  // read mux follows the registered address of each port
  assign c_sel = s_cadrs[XLEN-1 -: SELW];
  assign d_sel = s_dadrs[XLEN-1 -: SELW];
  assign c_din = s_dout[c_sel*XLEN +: XLEN];
  assign d_din = s_dout[d_sel*XLEN +: XLEN];

  bus_port_fsm #(
    .XLEN      (XLEN),
    .NSLOT     (NSLOT),
    .TIMEOUT   (TIMEOUT),
    .SLOT_EN   (SLOT_EN),
    .HAS_WRITE (1'b0)
  ) u_cport (
    .clk     (clk),
    .rst     (rst),
    .req     (c_req),
    .we      (1'b0),
    .adrs    (c_adrs),
    .din     (c_din),
    .s_ready (s_cready),
    .cs      (s_ccs),
    .adrs_q  (s_cadrs),
    .rdata   (c_rdata),
    .ready   (c_ready),
    .err     (c_err),
    .busy    (c_busy)
  );

  bus_port_fsm #(
    .XLEN      (XLEN),
    .NSLOT     (NSLOT),
    .TIMEOUT   (TIMEOUT),
    .SLOT_EN   (SLOT_EN),
    .HAS_WRITE (1'b1)
  ) u_dport (
    .clk     (clk),
    .rst     (rst),
    .req     (d_req),
    .we      (d_we),
    .adrs    (d_adrs),
    .din     (d_din),
    .s_ready (s_dready),
    .cs      (s_dcs),
    .adrs_q  (s_dadrs),
    .rdata   (d_rdata),
    .ready   (d_ready),
    .err     (d_err),
    .busy    (d_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s_dwe  <= 1'b0;
      s_dwst <= '0;
      s_din  <= '0;
    end else if (d_req && !d_busy) begin
      s_dwe  <= d_we;
      s_dwst <= d_wst;
      s_din  <= d_wdata;
    end
  end

  // edge slots hold until acked (a fresh edge beats the ack), level slots track
  assign rise   = s_irq & ~irq_hist;
  assign pend_n = (EDGE & (rise | (irq_pend & ~irq_ack)))
                | (~EDGE & s_irq);

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_hist <= '0;
      irq_pend <= '0;
      irq      <= 1'b0;
    end else begin
      irq_hist <= s_irq;
      irq_pend <= pend_n;
      irq      <= |(irq_pend & irq_en);
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: directed and random transactions
// plus interrupt latch checks against a behavioural model.
module tb_bus_fabric;

  localparam logic [15:0] SLOT_EN_TB = 16'h803f;
  localparam logic [15:0] EDGE_TB    = 16'h00f0;
  localparam int          TMO        = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         c_req;
  logic [31:0]  c_adrs;
  logic [31:0]  c_rdata;
  logic         c_ready, c_err, c_busy;
  logic         d_req, d_we;
  logic [3:0]   d_wst;
  logic [31:0]  d_adrs, d_wdata, d_rdata;
  logic         d_ready, d_err, d_busy;
  logic [15:0]  s_ccs, s_dcs;
  logic [31:0]  s_cadrs;
  logic         s_dwe;
  logic [3:0]   s_dwst;
  logic [31:0]  s_dadrs, s_din;
  logic [511:0] s_dout;
  logic [15:0]  s_cready, s_dready;
  logic [15:0]  s_irq, irq_en, irq_ack, irq_pend;
  logic         irq;

  int checks = 0;
  int failures = 0;

  logic [31:0] slot_data [16];
  logic [15:0] m_pend, m_prev;
  logic        m_irq;

  bus_fabric #(
    .XLEN     (32),
    .NSLOT    (16),
    .SLOT_EN  (SLOT_EN_TB),
    .TIMEOUT  (TMO),
    .IRQ_EDGE (EDGE_TB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .c_req    (c_req),
    .c_adrs   (c_adrs),
    .c_rdata  (c_rdata),
    .c_ready  (c_ready),
    .c_err    (c_err),
    .c_busy   (c_busy),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_wst    (d_wst),
    .d_adrs   (d_adrs),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .d_err    (d_err),
    .d_busy   (d_busy),
    .s_ccs    (s_ccs),
    .s_cadrs  (s_cadrs),
    .s_dcs    (s_dcs),
    .s_dwe    (s_dwe),
    .s_dwst   (s_dwst),
    .s_dadrs  (s_dadrs),
    .s_din    (s_din),
    .s_dout   (s_dout),
    .s_cready (s_cready),
    .s_dready (s_dready),
    .s_irq    (s_irq),
    .irq_en   (irq_en),
    .irq_ack  (irq_ack),
    .irq_pend (irq_pend),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // waits: ready after that many wait cycles; negative means never
  task automatic txn(input bit do_c, input logic [31:0] ca, input int cw,
                     input bit do_d, input logic dwe, input logic [31:0] da,
                     input logic [3:0] dst, input logic [31:0] dwd,
                     input int dw, input logic [31:0] dval);
    bit          act [2];
    int          slot [2], waits [2], lat [2], ncs [2];
    int          e_lat [2], e_ncs [2];
    logic        e_err [2], g_err [2];
    logic [31:0] e_rd [2], g_rd [2];
    logic [15:0] oh [2], cs_v [2], drv [2];
    logic        rdy_v [2], err_v [2], busy_v [2];
    logic [31:0] rd_v [2];
    bit          cs_ok [2], busy_ok [2];
    string       pn [2];
    pn[0] = "c";
    pn[1] = "d";
    for (int i = 0; i < 16; i++) slot_data[i] = $urandom;
    slot_data[da[31:28]] = dval;
    for (int i = 0; i < 16; i++) s_dout[i*32 +: 32] = slot_data[i];
    act[0] = do_c;
    act[1] = do_d;
    slot[0] = int'(ca[31:28]);
    slot[1] = int'(da[31:28]);
    waits[0] = cw;
    waits[1] = dw;
    for (int p = 0; p < 2; p++) begin
      oh[p] = 16'(1) << slot[p];
      lat[p] = 0;
      ncs[p] = 0;
      cs_ok[p] = 1'b1;
      busy_ok[p] = 1'b1;
      g_err[p] = 1'b0;
      g_rd[p] = '0;
      if (!SLOT_EN_TB[slot[p]]) begin
        e_lat[p] = 2; e_ncs[p] = 0; e_err[p] = 1'b1; e_rd[p] = '0;
      end else if (waits[p] < 0 || waits[p] > TMO) begin
        e_lat[p] = TMO + 2; e_ncs[p] = TMO + 1;
        e_err[p] = 1'b1; e_rd[p] = '0;
      end else begin
        e_lat[p] = waits[p] + 2; e_ncs[p] = waits[p] + 1; e_err[p] = 1'b0;
        e_rd[p] = (p == 1 && dwe) ? 32'h0 : slot_data[slot[p]];
      end
    end
    c_req = do_c; c_adrs = ca;
    d_req = do_d; d_we = dwe; d_adrs = da; d_wst = dst; d_wdata = dwd;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      c_req = 1'b0;
      d_req = 1'b0;
      cs_v[0] = s_ccs;    cs_v[1] = s_dcs;
      rdy_v[0] = c_ready; rdy_v[1] = d_ready;
      err_v[0] = c_err;   err_v[1] = d_err;
      rd_v[0] = c_rdata;  rd_v[1] = d_rdata;
      busy_v[0] = c_busy; busy_v[1] = d_busy;
      for (int p = 0; p < 2; p++) begin
        drv[p] = 16'($urandom) & ~oh[p];
        if (act[p] && lat[p] == 0) begin
          if (!busy_v[p]) busy_ok[p] = 1'b0;
          if (cs_v[p] != 0) begin
            ncs[p]++;
            if (cs_v[p] != oh[p]) cs_ok[p] = 1'b0;
          end
          if (rdy_v[p]) begin
            lat[p] = n; g_err[p] = err_v[p]; g_rd[p] = rd_v[p];
          end else if (cs_v[p] != 0 && waits[p] >= 0 &&
                       ncs[p] == waits[p] + 1) begin
            drv[p] = drv[p] | oh[p];
          end
        end
      end
      s_cready = drv[0];
      s_dready = drv[1];
      if ((!act[0] || lat[0] != 0) && (!act[1] || lat[1] != 0)) break;
    end
    s_cready = '0;
    s_dready = '0;
    for (int p = 0; p < 2; p++) begin
      if (act[p]) begin
        chk({pn[p], "_latency"}, 64'(lat[p]), 64'(e_lat[p]));
        chk({pn[p], "_err"}, 64'(g_err[p]), 64'(e_err[p]));
        chk({pn[p], "_rdata"}, 64'(g_rd[p]), 64'(e_rd[p]));
        chk({pn[p], "_cs_cycles"}, 64'(ncs[p]), 64'(e_ncs[p]));
        chk({pn[p], "_cs_onehot"}, 64'(cs_ok[p]), 64'(1));
        chk({pn[p], "_busy_hold"}, 64'(busy_ok[p]), 64'(1));
      end
    end
    if (do_c) chk("c_adrs_reg", 64'(s_cadrs), 64'(ca));
    if (do_d) begin
      chk("d_adrs_reg", 64'(s_dadrs), 64'(da));
      chk("d_we_reg", 64'(s_dwe), 64'(dwe));
      chk("d_wst_reg", 64'(s_dwst), 64'(dst));
      chk("d_din_reg", 64'(s_din), 64'(dwd));
    end
    @(posedge clk); #1;
    if (do_c) chk("c_idle_after", 64'({c_busy, c_ready}), 64'(0));
    if (do_d) chk("d_idle_after", 64'({d_busy, d_ready}), 64'(0));
  endtask

  // model: level slots mirror s_irq, edge slots latch rises until acked
  task automatic irq_step(input logic [15:0] si, input logic [15:0] en,
                          input logic [15:0] ack);
    logic [15:0] np;
    logic        ni;
    s_irq = si;
    irq_en = en;
    irq_ack = ack;
    ni = (m_pend & en) != 0;
    for (int i = 0; i < 16; i++) begin
      if (EDGE_TB[i]) np[i] = (si[i] && !m_prev[i]) || (m_pend[i] && !ack[i]);
      else np[i] = si[i];
    end
    m_prev = si;
    @(posedge clk); #1;
    m_pend = np;
    m_irq = ni;
    chk("irq_pend", 64'(irq_pend), 64'(m_pend));
    chk("irq", 64'(irq), 64'(m_irq));
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          rw1, rw2, nrdy;
    bit          b1, b2;
    rst = 1'b1;
    c_req = 0; c_adrs = '0;
    d_req = 0; d_we = 0; d_wst = '0; d_adrs = '0; d_wdata = '0;
    s_dout = '0; s_cready = '0; s_dready = '0;
    s_irq = '0; irq_en = '0; irq_ack = '0;
    m_pend = '0; m_prev = '0; m_irq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'({c_ready, d_ready, c_err, d_err}), 64'(0));
    chk("rst_busy", 64'({c_busy, d_busy}), 64'(0));
    chk("rst_cs", 64'({s_ccs, s_dcs}), 64'(0));
    chk("rst_rdata", 64'({c_rdata, d_rdata}), 64'(0));
    chk("rst_irq", 64'({irq_pend, irq}), 64'(0));
    chk("rst_dregs", 64'({s_dwe, s_dwst, s_din}), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    txn(0, '0, 0, 1, 0, 32'h40000004, 4'h0, 32'h0, 0, 32'h12345678);
    txn(0, '0, 0, 1, 1, 32'h30000000, 4'b0001, 32'ha5, 3, $urandom);
    txn(0, '0, 0, 1, 0, 32'h70000000, 4'h0, 32'h0, 0, $urandom);
    txn(0, '0, 0, 1, 0, 32'h50000000, 4'h0, 32'h0, -1, $urandom);
    txn(0, '0, 0, 1, 0, 32'h50000000, 4'h0, 32'h0, TMO, $urandom);
    txn(1, 32'h00000010, 0, 1, 0, 32'h00000020, 4'h0, 32'h0, 0, $urandom);
    txn(1, 32'hf0000100, 2, 0, 0, '0, 4'h0, 32'h0, 0, $urandom);
    txn(1, 32'h90000000, 1, 0, 0, '0, 4'h0, 32'h0, 0, $urandom);

    for (int k = 0; k < 24; k++) begin
      ra = $urandom; rb = $urandom;
      rw1 = int'($urandom_range(0, 19)) - 2;
      rw2 = int'($urandom_range(0, 19)) - 2;
      b1 = 1'($urandom_range(0, 1));
      b2 = !b1 || 1'($urandom_range(0, 1));
      txn(b1, ra, rw1, b2, 1'($urandom), rb, 4'($urandom), $urandom,
          rw2, $urandom);
    end

    d_req = 1'b1; d_we = 1'b0; d_adrs = 32'h50000000;
    @(posedge clk); #1;
    d_req = 1'b0;
    chk("mid_rst_cs_set", 64'(s_dcs), 64'(16'h0020));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_cs_drop", 64'({s_dcs, d_busy, d_ready}), 64'(0));
    nrdy = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (d_ready || s_dcs != 0) nrdy++;
    end
    chk("mid_rst_no_ready", 64'(nrdy), 64'(0));

    irq_step(16'h0000, 16'h0010, 16'h0000);
    irq_step(16'h0010, 16'h0010, 16'h0000);
    irq_step(16'h0000, 16'h0010, 16'h0000);
    chk("edge_pend_set", 64'(irq_pend[4]), 64'(1));
    irq_step(16'h0000, 16'h0010, 16'h0000);
    chk("edge_irq_hold", 64'(irq), 64'(1));
    irq_step(16'h0000, 16'h0010, 16'h0010);
    chk("edge_ack_clear", 64'(irq_pend[4]), 64'(0));
    irq_step(16'h0000, 16'h0010, 16'h0000);
    chk("edge_irq_drop", 64'(irq), 64'(0));
    irq_step(16'h0010, 16'h0010, 16'h0000);
    irq_step(16'h0000, 16'h0010, 16'h0000);
    irq_step(16'h0010, 16'h0010, 16'h0010);
    chk("edge_ack_vs_set", 64'(irq_pend[4]), 64'(1));
    irq_step(16'h0000, 16'h0010, 16'h0000);
    chk("edge_ack_vs_set_irq", 64'(irq), 64'(1));
    irq_step(16'h0001, 16'h0001, 16'h0001);
    chk("level_ack_ignored", 64'(irq_pend[0]), 64'(1));
    for (int k = 0; k < 60; k++) begin
      irq_step(16'($urandom), 16'($urandom),
               16'($urandom) & 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
